wb_collect: RTL and testbench
=============================

# wb_collect

Writeback collection stage that receives per-lane execution results from the EX pipelines over a valid/ready handshake. It buffers the results per lane and presents them to the ROB completion ports, which can apply bank-conflict backpressure. It sits between EX and the ROB. It decouples ROB backpressure from EX timing and drops in-flight results on a pipeline flush.

## Interface
- CONFIG_DW, 64, data width of the wb_opera and wb_operb lanes
- CONFIG_P_ISSUE_WIDTH, 1, log2 of lane count; IW = 1<<CONFIG_P_ISSUE_WIDTH
- CONFIG_P_ROB_DEPTH, 4, ROB index width
- CONFIG_P_COMMIT_WIDTH, 1, ROB bank index width
- clk  in  1  clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush; discards all buffered results
- wb_valid  in  IW  per-lane EX result valid
- wb_ready  out  IW  per-lane accept
- wb_rob_id  in  IW*CONFIG_P_ROB_DEPTH  ROB entry index
- wb_rob_bank  in  IW*CONFIG_P_COMMIT_WIDTH  ROB bank
- wb_fls  in  IW  flush request (branch mispredict)
- wb_exc  in  IW  exception raised
- wb_opera / wb_operb  in  IW*CONFIG_DW each  exception/EPU operands
- wb_fls_tgt  in  IW*`PC_W  redirect target
- rob_done_valid  out  IW  completion write to the ROB
- rob_done_ready  in  IW  ROB accepts the write (low on bank conflict)
- rob_done_id / rob_done_bank / rob_done_fls / rob_done_exc / rob_done_opera / rob_done_operb / rob_done_fls_tgt  out  same widths as the corresponding wb_* inputs; buffered payload
- stall_cnt  out  IW*16  per-lane count of cycles with rob_done_valid & ~rob_done_ready; saturates

## Operation
- Lanes are fully independent. Each lane is a FIFO of depth D: D=2 with the skid buffer built in, D=1 without it.
- An EX handshake is wb_valid[i] & wb_ready[i]. On a handshake, the payload is pushed at the tail.
- A ROB handshake is rob_done_valid[i] & rob_done_ready[i]. On a ROB handshake, the head is popped.
- rob_done_valid[i] = lane not empty. rob_done_* always carry the head entry.
- Push and pop in the same cycle: occupancy is unchanged and order is preserved. When the lane is full, the push is legal only under the rule in Configuration.
- Per-lane occupancy states: EMPTY, ONE, TWO (TWO exists only with the skid buffer). Transitions:
  - push only: +1
  - pop only: -1
  - push and pop together: hold
- flush: the next state of every lane is EMPTY, regardless of any push or pop in the same cycle. Results accepted in the flush cycle are discarded. stall_cnt is not cleared.
- stall_cnt[i] increments by 1 each cycle rob_done_valid[i] & ~rob_done_ready[i]. It saturates at 16'hFFFF. It is not cleared by flush.
- Payload registers are not reset; only the occupancy state and counters are reset.

## Timing
- Reset, asynchronous: every lane EMPTY; rob_done_valid=0; stall_cnt=0. wb_ready equals its reset-derived value (all 1s).
- Latency: a result accepted at edge N appears on rob_done_* at edge N, visible in cycle N+1. Minimum latency is 1 cycle; no combinational EX-to-ROB path.
- Throughput: 1 result per lane per cycle while rob_done_ready stays high.
- rob_done_valid never drops without a ROB handshake, except on flush or reset.
- rob_done_* payload is stable while valid is held.
- Reset asserted mid-transfer: all buffered results are lost and the lane is EMPTY immediately. Deassertion is synchronised by the reset generator upstream.

## Configuration
- NCPU_WB_SKID_EN defined:
  - D=2 per lane.
  - wb_ready[i] = (state != TWO). It is a pure register output with no path from rob_done_ready.
  - Sustains full throughput with a registered ready.
- NCPU_WB_SKID_EN undefined:
  - D=1 per lane.
  - wb_ready[i] = EMPTY | rob_done_ready[i]. This is a combinational path from ROB to EX; a push into a full lane is legal only when the head pops in the same cycle.
  - Uses fewer registers.

## Test plan
- Single lane, rob_done_ready=1, one result per cycle with rob_id 0..7 -> rob_done_id 0..7 on consecutive cycles, each 1 cycle after acceptance; wb_ready stays 1.
- Lane 0 with rob_done_ready=0 for 3 cycles while EX offers ids 5,6,7:
  - skid on: ids 5 and 6 accepted, then wb_ready=0; after release, outputs are 5,6,7 in order; stall_cnt[0]=3.
  - skid off: only id 5 is accepted.
- Two lanes with opposite ready patterns (lane0 ready=1010..., lane1 ready=0101...) -> no cross-lane coupling; per-lane output order matches input order.
- Both lanes full with flush asserted while wb_valid=1 and fls=1 -> next cycle rob_done_valid=0 and all lanes EMPTY; the result offered in the flush cycle never appears.
- rst_n pulsed low mid-stream with two entries buffered -> rob_done_valid=0 during reset; stall_cnt=0; after release, the first new result appears with 1-cycle latency.
- stall_cnt preloaded via 65540 consecutive stall cycles -> holds 16'hFFFF, no wrap.

Source files
------------

// File: rtl/wb_collect.sv
`default_nettype none
// ============================================================================
//  Module      : wb_collect
//  Description : Writeback collection stage between the EX pipelines and the
//                ROB completion ports. Each issue lane owns a small in-order
//                FIFO that accepts EX results over a valid/ready handshake and
//                presents the head entry to the ROB. The ROB may refuse a write
//                (bank conflict), and the per-lane FIFO absorbs that
//                backpressure. A pipeline flush empties every lane at once.
//
//  Optional feature macro: NCPU_WB_SKID_EN
//    defined   : 2-entry lane (skid buffer), wb_ready is a flop output with no
//                path from rob_done_ready.
//    undefined : 1-entry lane, wb_ready = empty | rob_done_ready (combinational
//                ROB-to-EX path; refill of a full lane only while it pops).
//
//  Ports (IW = 1 << CONFIG_P_ISSUE_WIDTH lanes, all buses lane-packed, lane 0
//  in the least significant slice):
//    clk, rst_n           clock, asynchronous active-low reset
//    flush                discard all buffered results
//    wb_valid / wb_ready  EX handshake, one bit per lane
//    wb_rob_id, wb_rob_bank, wb_fls, wb_exc, wb_opera, wb_operb, wb_fls_tgt
//                         EX result payload
//    rob_done_valid / rob_done_ready
//                         ROB completion handshake, one bit per lane
//    rob_done_*           head-of-lane payload
//    stall_cnt            per-lane 16-bit saturating count of ROB stall cycles
//
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef PC_W
`define PC_W 32
`endif

module wb_collect #(
    parameter int CONFIG_DW             = 64,
    parameter int CONFIG_P_ISSUE_WIDTH  = 1,
    parameter int CONFIG_P_ROB_DEPTH    = 4,
    parameter int CONFIG_P_COMMIT_WIDTH = 1
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  flush,
    // EX side
    input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                  wb_valid,
    output logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                  wb_ready,
    input  logic [(1<<CONFIG_P_ISSUE_WIDTH)*CONFIG_P_ROB_DEPTH-1:0]    wb_rob_id,
    input  logic [(1<<CONFIG_P_ISSUE_WIDTH)*CONFIG_P_COMMIT_WIDTH-1:0] wb_rob_bank,
    input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                  wb_fls,
    input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                  wb_exc,
    input  logic [(1<<CONFIG_P_ISSUE_WIDTH)*CONFIG_DW-1:0]        wb_opera,
    input  logic [(1<<CONFIG_P_ISSUE_WIDTH)*CONFIG_DW-1:0]        wb_operb,
    input  logic [(1<<CONFIG_P_ISSUE_WIDTH)*`PC_W-1:0]            wb_fls_tgt,
    // ROB side
    output logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                  rob_done_valid,
    input  logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                  rob_done_ready,
    output logic [(1<<CONFIG_P_ISSUE_WIDTH)*CONFIG_P_ROB_DEPTH-1:0]    rob_done_id,
    output logic [(1<<CONFIG_P_ISSUE_WIDTH)*CONFIG_P_COMMIT_WIDTH-1:0] rob_done_bank,
    output logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                  rob_done_fls,
    output logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]                  rob_done_exc,
    output logic [(1<<CONFIG_P_ISSUE_WIDTH)*CONFIG_DW-1:0]        rob_done_opera,
    output logic [(1<<CONFIG_P_ISSUE_WIDTH)*CONFIG_DW-1:0]        rob_done_operb,
    output logic [(1<<CONFIG_P_ISSUE_WIDTH)*`PC_W-1:0]            rob_done_fls_tgt,
    // Statistics
    output logic [(1<<CONFIG_P_ISSUE_WIDTH)*16-1:0]               stall_cnt
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int c_iw = 1 << CONFIG_P_ISSUE_WIDTH;
    localparam int c_rw = CONFIG_P_ROB_DEPTH;
    localparam int c_bw = CONFIG_P_COMMIT_WIDTH;
    localparam int c_dw = CONFIG_DW;
    localparam int c_tw = `PC_W;
    // Packed entry: {rob_id, bank, fls, exc, opera, operb, fls_tgt}
    localparam int c_pw = c_rw + c_bw + 2 + 2 * c_dw + c_tw;

    localparam logic [15:0] c_stall_max = 16'hFFFF;

    // Lane occupancy encoding
    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
`ifdef NCPU_WB_SKID_EN
    localparam logic [1:0] c_st_two   = 2'd2;
`endif

    // ------------------------------------------------------------------------
    // Per-lane FIFO
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < c_iw; gi++) begin : g_lane
        logic [c_pw-1:0] w_in_pl;
        logic [c_pw-1:0] r_head;
        logic [1:0]      r_state;
        logic [1:0]      w_state_nxt;
        logic            w_out_valid;
        logic            w_in_ready;
        logic            w_push;
        logic            w_pop;
        logic [15:0]     r_stall;

        assign w_in_pl = {wb_rob_id  [gi*c_rw +: c_rw],
                          wb_rob_bank[gi*c_bw +: c_bw],
                          wb_fls     [gi],
                          wb_exc     [gi],
                          wb_opera   [gi*c_dw +: c_dw],
                          wb_operb   [gi*c_dw +: c_dw],
                          wb_fls_tgt [gi*c_tw +: c_tw]};

        assign w_out_valid = (r_state != c_st_empty);
        assign w_push      = wb_valid[gi] & w_in_ready;
        assign w_pop       = w_out_valid & rob_done_ready[gi];

        // Occupancy next state. Flush overrides any same-cycle push/pop, so
        // a result accepted in the flush cycle is dropped with the rest.
        always_comb begin
            w_state_nxt = r_state;
            if (flush) begin
                w_state_nxt = c_st_empty;
            end else if (w_push && !w_pop) begin
                case (r_state)
                    c_st_empty: w_state_nxt = c_st_one;
`ifdef NCPU_WB_SKID_EN
                    c_st_one:   w_state_nxt = c_st_two;
`endif
                    default:    w_state_nxt = r_state;
                endcase
            end else if (w_pop && !w_push) begin
                case (r_state)
`ifdef NCPU_WB_SKID_EN
                    c_st_two:   w_state_nxt = c_st_one;
`endif
                    default:    w_state_nxt = c_st_empty;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= c_st_empty;
            end else begin
                r_state <= w_state_nxt;
            end
        end

`ifdef NCPU_WB_SKID_EN
        // Two-entry lane: r_head is the entry shown to the ROB, r_skid holds
        // the second (younger) entry while the head is blocked.
        logic [c_pw-1:0] r_skid;
        logic            r_ready;

        always_ff @(posedge clk) begin
            if (w_pop) begin
                if (r_state == c_st_two) begin
                    // Younger entry moves up; no push can coincide because
                    // ready is low while the lane is full.
                    r_head <= r_skid;
                end else if (w_push) begin
                    r_head <= w_in_pl;
                end
            end else if (w_push) begin
                if (r_state == c_st_empty) begin
                    r_head <= w_in_pl;
                end else begin
                    r_skid <= w_in_pl;
                end
            end
        end

        // Ready is precomputed from the next occupancy so the EX side sees a
        // plain flop output, independent of rob_done_ready in this cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ready <= 1'b1;
            end else begin
                r_ready <= (w_state_nxt != c_st_two);
            end
        end

        assign w_in_ready = r_ready;
`else
        // Single-entry lane: a full lane may only be refilled in the cycle
        // its head leaves, so ready follows the ROB ready combinationally.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_head <= w_in_pl;
            end
        end

        assign w_in_ready = (r_state == c_st_empty) | rob_done_ready[gi];
`endif

        // Saturating count of cycles the ROB refused a valid completion.
        // Only reset clears it; flush leaves it alone.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stall <= '0;
            end else if (w_out_valid && !rob_done_ready[gi] && (r_stall != c_stall_max)) begin
                r_stall <= r_stall + 16'd1;
            end
        end

        assign {rob_done_id     [gi*c_rw +: c_rw],
                rob_done_bank   [gi*c_bw +: c_bw],
                rob_done_fls    [gi],
                rob_done_exc    [gi],
                rob_done_opera  [gi*c_dw +: c_dw],
                rob_done_operb  [gi*c_dw +: c_dw],
                rob_done_fls_tgt[gi*c_tw +: c_tw]} = r_head;

        assign rob_done_valid[gi]      = w_out_valid;
        assign wb_ready[gi]            = w_in_ready;
        assign stall_cnt[gi*16 +: 16]  = r_stall;
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_collect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_collect
//  Description : Self-checking bench for wb_collect. A queue-per-lane
//                reference model predicts handshakes, head payload, ready and
//                stall counters every cycle; a vector table and directed
//                sequences cover backpressure, flush, reset and saturation.
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef PC_W
`define PC_W 32
`endif

module tb_wb_collect;

    localparam int IW = 2;
    localparam int RW = 4;
    localparam int BW = 1;
    localparam int DW = 64;
    localparam int TW = `PC_W;
`ifdef NCPU_WB_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [RW-1:0] id;
        logic [BW-1:0] bank;
        logic          fls;
        logic          exc;
        logic [DW-1:0] opera;
        logic [DW-1:0] operb;
        logic [TW-1:0] tgt;
    } payload_t;

    typedef struct {
        logic          v;
        logic [RW-1:0] id;
        logic          rr;
        logic          dv;
        logic [RW-1:0] did;
        logic          wr;
        logic [15:0]   st;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush;
    logic [IW-1:0]       wb_valid, wb_ready, wb_fls, wb_exc;
    logic [IW*RW-1:0]    wb_rob_id;
    logic [IW*BW-1:0]    wb_rob_bank;
    logic [IW*DW-1:0]    wb_opera, wb_operb;
    logic [IW*TW-1:0]    wb_fls_tgt;
    logic [IW-1:0]       rob_done_valid, rob_done_ready, rob_done_fls, rob_done_exc;
    logic [IW*RW-1:0]    rob_done_id;
    logic [IW*BW-1:0]    rob_done_bank;
    logic [IW*DW-1:0]    rob_done_opera, rob_done_operb;
    logic [IW*TW-1:0]    rob_done_fls_tgt;
    logic [IW*16-1:0]    stall_cnt;

    wb_collect dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_rob_id        (wb_rob_id),
        .wb_rob_bank      (wb_rob_bank),
        .wb_fls           (wb_fls),
        .wb_exc           (wb_exc),
        .wb_opera         (wb_opera),
        .wb_operb         (wb_operb),
        .wb_fls_tgt       (wb_fls_tgt),
        .rob_done_valid   (rob_done_valid),
        .rob_done_ready   (rob_done_ready),
        .rob_done_id      (rob_done_id),
        .rob_done_bank    (rob_done_bank),
        .rob_done_fls     (rob_done_fls),
        .rob_done_exc     (rob_done_exc),
        .rob_done_opera   (rob_done_opera),
        .rob_done_operb   (rob_done_operb),
        .rob_done_fls_tgt (rob_done_fls_tgt),
        .stall_cnt        (stall_cnt)
    );

    initial forever #5 clk = ~clk;

    // Stimulus for the current cycle
    logic     in_v   [IW];
    logic     in_rr  [IW];
    payload_t in_pl  [IW];
    logic     in_flush;

    // Reference model
    payload_t mq     [IW][$];
    int       mstall [IW];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int lane, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane%0d: got %0h expected %0h (t=%0t)", nm, lane, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready(input int l);
        if (CAP == 2) return (mq[l].size() < 2);
        return (mq[l].size() == 0) || in_rr[l];
    endfunction

    function automatic payload_t act_pl(input int l);
        payload_t p;
        p.id    = rob_done_id[l*RW +: RW];
        p.bank  = rob_done_bank[l*BW +: BW];
        p.fls   = rob_done_fls[l];
        p.exc   = rob_done_exc[l];
        p.opera = rob_done_opera[l*DW +: DW];
        p.operb = rob_done_operb[l*DW +: DW];
        p.tgt   = rob_done_fls_tgt[l*TW +: TW];
        return p;
    endfunction

    function automatic payload_t rand_pl(input logic [RW-1:0] id);
        payload_t p;
        p.id    = id;
        p.bank  = BW'($urandom);
        p.fls   = 1'($urandom);
        p.exc   = 1'($urandom);
        p.opera = {$urandom, $urandom};
        p.operb = {$urandom, $urandom};
        p.tgt   = TW'($urandom);
        return p;
    endfunction

    function automatic void model_clear();
        for (int l = 0; l < IW; l++) mq[l].delete();
    endfunction

    // Called at the falling edge: apply stimulus, let it settle, compare.
    task automatic drive_and_check();
        for (int l = 0; l < IW; l++) begin
            wb_valid[l]               = in_v[l];
            rob_done_ready[l]         = in_rr[l];
            wb_rob_id[l*RW +: RW]     = in_pl[l].id;
            wb_rob_bank[l*BW +: BW]   = in_pl[l].bank;
            wb_fls[l]                 = in_pl[l].fls;
            wb_exc[l]                 = in_pl[l].exc;
            wb_opera[l*DW +: DW]      = in_pl[l].opera;
            wb_operb[l*DW +: DW]      = in_pl[l].operb;
            wb_fls_tgt[l*TW +: TW]    = in_pl[l].tgt;
        end
        flush = in_flush;
        #1;
        for (int l = 0; l < IW; l++) begin
            logic ev;
            logic er;
            ev = (mq[l].size() > 0);
            er = exp_ready(l);
            chk("valid_ready", l, 192'({rob_done_valid[l], wb_ready[l]}), 192'({ev, er}));
            chk("stall_cnt", l, 192'(stall_cnt[l*16 +: 16]), 192'(mstall[l]));
            if (ev) chk("payload", l, 192'(act_pl(l)), 192'(mq[l][0]));
        end
    endtask

    // Update the model with this cycle's handshakes, then move to the next
    // falling edge.
    task automatic advance();
        bit push [IW];
        bit pop  [IW];
        for (int l = 0; l < IW; l++) begin
            push[l] = in_v[l] && exp_ready(l);
            pop[l]  = (mq[l].size() > 0) && in_rr[l];
            if ((mq[l].size() > 0) && !in_rr[l] && (mstall[l] < 65535)) mstall[l]++;
        end
        if (in_flush) begin
            model_clear();
        end else begin
            for (int l = 0; l < IW; l++) begin
                if (pop[l])  void'(mq[l].pop_front());
                if (push[l]) mq[l].push_back(in_pl[l]);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int l = 0; l < IW; l++) begin
            in_v[l]  = 1'b0;
            in_rr[l] = 1'b1;
            in_pl[l] = rand_pl(4'd0);
        end
        in_flush = 1'b0;
    endtask

    // Watchdog
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl [8];
    int   idc [IW];

    initial begin
        // ---------------- Reset ----------------
        rst_n = 1'b0;
        idle_inputs();
        for (int l = 0; l < IW; l++) mstall[l] = 0;
        model_clear();
        wb_valid = '0; rob_done_ready = '1; flush = 1'b0;
        wb_rob_id = '0; wb_rob_bank = '0; wb_fls = '0; wb_exc = '0;
        wb_opera = '0; wb_operb = '0; wb_fls_tgt = '0;
        @(negedge clk);
        #1;
        chk("rst_valid", 0, 192'(rob_done_valid), 192'(2'b00));
        chk("rst_ready", 0, 192'(wb_ready), 192'(2'b11));
        chk("rst_stall", 0, 192'(stall_cnt), 192'(32'd0));
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- Vector table: lane 0 under ROB stall ----------------
        //            v  id    rr  dv  did   wr  stall
        tbl[0] = '{1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b1, 16'd0};
        tbl[1] = '{1'b1, 4'd6, 1'b0, 1'b1, 4'd5, 1'b1, 16'd0};
        tbl[2] = '{1'b1, 4'd7, 1'b0, 1'b1, 4'd5, 1'b0, 16'd1};
        tbl[3] = '{1'b1, 4'd7, 1'b0, 1'b1, 4'd5, 1'b0, 16'd2};
        tbl[4] = '{1'b1, 4'd7, 1'b1, 1'b1, 4'd5, 1'b0, 16'd3};
        tbl[5] = '{1'b1, 4'd7, 1'b1, 1'b1, 4'd6, 1'b1, 16'd3};
        tbl[6] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd7, 1'b1, 16'd3};
        tbl[7] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 16'd3};
`ifndef NCPU_WB_SKID_EN
        // Single entry: id 6 is never taken, ready follows the ROB.
        tbl[1].wr  = 1'b0;
        tbl[4].wr  = 1'b1;
        tbl[5].did = 4'd7;
`endif
        for (int k = 0; k < 8; k++) begin
            in_v[0]  = tbl[k].v;
            in_rr[0] = tbl[k].rr;
            in_pl[0] = rand_pl(tbl[k].id);
            drive_and_check();
            chk("tbl_valid", 0, 192'(rob_done_valid[0]), 192'(tbl[k].dv));
            chk("tbl_ready", 0, 192'(wb_ready[0]), 192'(tbl[k].wr));
            chk("tbl_stall", 0, 192'(stall_cnt[15:0]), 192'(tbl[k].st));
            if (tbl[k].dv) chk("tbl_id", 0, 192'(rob_done_id[3:0]), 192'(tbl[k].did));
            advance();
        end

        // ---------------- Streaming ids 0..7, 1-cycle latency ----------------
        idle_inputs();
        for (int k = 0; k <= 8; k++) begin
            in_v[0]  = (k < 8);
            in_pl[0] = rand_pl(RW'(k));
            drive_and_check();
            chk("stream_ready", 0, 192'(wb_ready[0]), 192'(1'b1));
            if (k > 0) begin
                chk("stream_valid", 0, 192'(rob_done_valid[0]), 192'(1'b1));
                chk("stream_id", 0, 192'(rob_done_id[3:0]), 192'(k - 1));
            end
            advance();
        end

        // ---------------- Opposite ready patterns on two lanes ----------------
        idle_inputs();
        idc[0] = 0; idc[1] = 0;
        for (int c = 0; c < 24; c++) begin
            bit acc [IW];
            for (int l = 0; l < IW; l++) begin
                in_v[l]  = 1'b1;
                in_rr[l] = (l == 0) ? !c[0] : c[0];
                in_pl[l] = rand_pl(RW'(idc[l]));
            end
            for (int l = 0; l < IW; l++) acc[l] = exp_ready(l);
            drive_and_check();
            advance();
            for (int l = 0; l < IW; l++) if (acc[l]) idc[l]++;
        end

        // ---------------- Flush with both lanes full ----------------
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            for (int l = 0; l < IW; l++) begin
                in_v[l]  = 1'b1;
                in_rr[l] = 1'b0;
                in_pl[l] = rand_pl(RW'(8 + c));
            end
            drive_and_check();
            advance();
        end
        for (int l = 0; l < IW; l++) begin
            in_pl[l]     = rand_pl(4'hF);
            in_pl[l].fls = 1'b1;
        end
        in_flush = 1'b1;
        drive_and_check();
        advance();
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            drive_and_check();
            chk("flush_empty", 0, 192'(rob_done_valid), 192'(2'b00));
            advance();
        end

        // ---------------- Reset mid-stream ----------------
        for (int c = 0; c < 3; c++) begin
            for (int l = 0; l < IW; l++) begin
                in_v[l]  = 1'b1;
                in_rr[l] = 1'b0;
                in_pl[l] = rand_pl(RW'(2 + c));
            end
            drive_and_check();
            advance();
        end
        idle_inputs();
        for (int l = 0; l < IW; l++) in_rr[l] = 1'b0;
        drive_and_check();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 0, 192'(rob_done_valid), 192'(2'b00));
        chk("arst_stall", 0, 192'(stall_cnt), 192'(32'd0));
        model_clear();
        for (int l = 0; l < IW; l++) mstall[l] = 0;
        @(posedge clk);
        #1;
        chk("arst_hold_valid", 0, 192'(rob_done_valid), 192'(2'b00));
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        in_v[0]  = 1'b1;
        in_pl[0] = rand_pl(4'd9);
        drive_and_check();
        advance();
        in_v[0] = 1'b0;
        drive_and_check();
        chk("post_rst_valid", 0, 192'(rob_done_valid[0]), 192'(1'b1));
        chk("post_rst_id", 0, 192'(rob_done_id[3:0]), 192'(4'd9));
        advance();

        // ---------------- Stall counter saturation ----------------
        idle_inputs();
        in_v[0]  = 1'b1;
        in_pl[0] = rand_pl(4'd3);
        drive_and_check();
        advance();
        in_v[0]  = 1'b0;
        in_rr[0] = 1'b0;
        for (int c = 0; c < 65540; c++) begin
            drive_and_check();
            advance();
        end
        chk("stall_sat", 0, 192'(stall_cnt[15:0]), 192'(16'hFFFF));
        in_flush = 1'b1;
        drive_and_check();
        advance();
        idle_inputs();
        drive_and_check();
        chk("stall_keep_flush", 0, 192'(stall_cnt[15:0]), 192'(16'hFFFF));
        advance();

        // ---------------- Randomized traffic ----------------
        for (int c = 0; c < 1500; c++) begin
            for (int l = 0; l < IW; l++) begin
                in_v[l]  = 1'($urandom_range(0, 1));
                in_rr[l] = ($urandom_range(0, 3) != 0);
                in_pl[l] = rand_pl(RW'($urandom));
            end
            in_flush = ($urandom_range(0, 39) == 0);
            drive_and_check();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
